multi_mul: RTL and testbench
============================

// Module: multi_mul
// PURPOSE
// - Column multiplier of the conv datapath.
// - Multiplies one feature-map pixel by a full kernel weight column,
//   with NO_COL_KERNEL lanes working in parallel.
// - Emits one registered product column per accepted beat.
// - Counts beats to track the kernel-column index; the downstream accumulator consumes the products.
// PARAMETERS
// - BIT_WIDTH      8  width of each weight and of the pixel
// - NO_COL_KERNEL  5  number of lanes (weights per column) and kernel-column wrap count; legal range 1..8
// PORTS
// - i_clk              in   1                      clock, rising edge
// - i_rst_n            in   1                      asynchronous active-low reset
// - i_weight_col       in   BIT_WIDTH*NO_COL_KERNEL  lane k = [k*BIT_WIDTH +: BIT_WIDTH]
// - i_pix_feature_map  in   BIT_WIDTH              pixel shared by all lanes
// - o_feature_map_col  out  2*BIT_WIDTH*NO_COL_KERNEL  lane k = [k*2*BIT_WIDTH +: 2*BIT_WIDTH]
// - o_kercol_cnt       out  3                      kernel-column index of the data on o_feature_map_col
// - i_enable_colw      in   1                      weight column valid
// - i_enable_colip     in   1                      pixel valid
// - o_ready            out  1                      o_feature_map_col updated this cycle (1-cycle pulse per beat)
// - o_start            out  1                      pulse: current output is column 0 of a kernel
// BEHAVIOUR
// - Reset (async, i_rst_n=0): all outputs 0; internal next-index pointer 0.
// - Accept: a rising edge with i_enable_colw & i_enable_colip both 1.
//   - Either enable low means no accept, regardless of the other.
// - On accept, lane k of o_feature_map_col <= weight_k * pixel.
//   - Product is full 2*BIT_WIDTH bits; no truncation or saturation.
//   - Default arithmetic is unsigned.
// - Latency: 1 clock. Output is visible after the accepting edge.
//   - Back-to-back accepts give a new column every cycle (throughput 1/clk).
// - o_ready: registered; 1 for the cycle after each accept, else 0.
// - o_kercol_cnt <= pointer on accept.
//   - Pointer then advances; it wraps from NO_COL_KERNEL-1 to 0.
// - o_start: registered; 1 when o_ready=1 and o_kercol_cnt=0, else 0.
// - No accept:
//   - o_feature_map_col and o_kercol_cnt hold their values.
//   - o_ready=0, o_start=0.
//   - Pointer holds, so a stalled kernel resumes at the next index.
// - Reset mid-kernel: pointer returns to 0; the next accept raises o_start.
// - Inputs are sampled only on accepting edges; input changes between edges have no effect.
// CONFIGURATION
// - MULTI_MUL_SIGNED_EN defined:
//   - Weights, pixel and products are two's-complement signed.
//   - Products are sign-extended to 2*BIT_WIDTH.
// - MULTI_MUL_SIGNED_EN undefined: all operands and products unsigned (default).
// - The macro changes no other behaviour, timing or port.
// TESTING (BIT_WIDTH=8, NO_COL_KERNEL=5)
// - Reset: hold i_rst_n=0 with enables high
//   -> outputs 0, o_ready=0, o_start=0, o_kercol_cnt=0.
// - Single beat: pixel=3, lanes {1,2,3,4,5} (lane0=1), both enables 1 for one edge
//   -> next cycle lanes {3,6,9,12,15}, o_ready=1, o_start=1, o_kercol_cnt=0.
//   -> following cycle o_ready=0 and data held.
// - Six consecutive beats with random data:
//   -> o_kercol_cnt 0,1,2,3,4,0.
//   -> o_start on beats 1 and 6 only; each lane equals the exact product.
// - Extremes: pixel=8'hFF, all weights 8'hFF
//   -> unsigned build: every lane 16'hFE01.
//   -> MULTI_MUL_SIGNED_EN build: every lane 16'h0001.
//   -> pixel 8'h80 * weight 8'h7F -> 16'hC080 (signed build).
// - Gating: only i_enable_colw=1 (then only i_enable_colip=1) for 3 cycles
//   -> o_ready=0, outputs and count held.
//   -> next full accept continues the count.
// - Mid-operation reset after output at o_kercol_cnt=2
//   -> outputs clear asynchronously.
//   -> next accept gives o_kercol_cnt=0, o_start=1.

Source files
------------

// File: rtl/multi_mul.sv
// multi_mul: one pixel times a kernel weight column, NO_COL_KERNEL lanes, registered, with kernel-column tracking.
// Define MULTI_MUL_SIGNED_EN for two's-complement operands and products (default unsigned).
module multi_mul #(
    parameter int BIT_WIDTH     = 8,
    parameter int NO_COL_KERNEL = 5
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [BIT_WIDTH*NO_COL_KERNEL-1:0]   i_weight_col,
    input  logic [BIT_WIDTH-1:0]                 i_pix_feature_map,
    output logic [2*BIT_WIDTH*NO_COL_KERNEL-1:0] o_feature_map_col,
    output logic [2:0]                           o_kercol_cnt,
    input  logic                                 i_enable_colw,
    input  logic                                 i_enable_colip,
    output logic                                 o_ready,
    output logic                                 o_start
);
    localparam int PW = 2 * BIT_WIDTH;

    logic                            accept;
    logic [2:0]                      ptr, ptr_next;
    logic [PW*NO_COL_KERNEL-1:0]     col_next;
    logic [PW-1:0]                   pix_ext;

    assign accept   = i_enable_colw & i_enable_colip;
    assign ptr_next = (ptr == 3'(NO_COL_KERNEL - 1)) ? 3'd0 : ptr + 3'd1;

    // Extending both operands to full product width keeps the low bits exact for either signedness.
`ifdef MULTI_MUL_SIGNED_EN
    assign pix_ext = {{BIT_WIDTH{i_pix_feature_map[BIT_WIDTH-1]}}, i_pix_feature_map};
`else
    assign pix_ext = {{BIT_WIDTH{1'b0}}, i_pix_feature_map};
`endif

    for (genvar k = 0; k < NO_COL_KERNEL; k++) begin : g_lane
        logic [BIT_WIDTH-1:0] w;
        logic [PW-1:0]        w_ext;
        assign w = i_weight_col[k*BIT_WIDTH +: BIT_WIDTH];
`ifdef MULTI_MUL_SIGNED_EN
        assign w_ext = {{BIT_WIDTH{w[BIT_WIDTH-1]}}, w};
`else
        assign w_ext = {{BIT_WIDTH{1'b0}}, w};
`endif
        assign col_next[k*PW +: PW] = w_ext * pix_ext;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_feature_map_col <= '0;
            o_kercol_cnt      <= '0;
            o_ready           <= 1'b0;
            o_start           <= 1'b0;
            ptr               <= '0;
        end else begin
            o_ready <= accept;
            o_start <= accept && (ptr == 3'd0);
            if (accept) begin
                o_feature_map_col <= col_next;
                o_kercol_cnt      <= ptr;
                ptr               <= ptr_next;
            end
        end
    end
endmodule

// File: tb/tb_multi_mul.sv
// tb_multi_mul: directed checks of multi_mul (BIT_WIDTH=8, NO_COL_KERNEL=5).
module tb_multi_mul;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] weight_col = '0;
    logic [7:0]  pix = '0;
    logic        en_w = 1'b0, en_p = 1'b0;
    logic [79:0] col;
    logic [2:0]  cnt;
    logic        ready, start;
    int          checks = 0, errors = 0;
    logic [79:0] exp_col;

    multi_mul #(.BIT_WIDTH(8), .NO_COL_KERNEL(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_weight_col(weight_col),
        .i_pix_feature_map(pix), .o_feature_map_col(col), .o_kercol_cnt(cnt),
        .i_enable_colw(en_w), .i_enable_colip(en_p), .o_ready(ready), .o_start(start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [79:0] c, input logic [2:0] n,
                           input logic r, input logic s);
        chk({tag, ".col"}, col, c);
        chk({tag, ".cnt"}, 80'(cnt), 80'(n));
        chk({tag, ".ready"}, 80'(ready), 80'(r));
        chk({tag, ".start"}, 80'(start), 80'(s));
    endtask

    function automatic logic [79:0] model(input logic [39:0] w, input logic [7:0] p);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            int a, b;
            logic [7:0] wk;
            wk = w[k*8 +: 8];
`ifdef MULTI_MUL_SIGNED_EN
            a = int'($signed(wk));
            b = int'($signed(p));
`else
            a = int'(wk);
            b = int'(p);
`endif
            r[k*16 +: 16] = 16'(a * b);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        en_w = 1'b0; en_p = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic beat(input logic [39:0] w, input logic [7:0] p);
        weight_col = w; pix = p; en_w = 1'b1; en_p = 1'b1;
        step();
        en_w = 1'b0; en_p = 1'b0;
    endtask

    initial begin
        // reset held with enables high and live data
        en_w = 1'b1; en_p = 1'b1; pix = 8'h55; weight_col = 40'h1122334455;
        step();
        step();
        chk_out("reset", 80'h0, 3'd0, 1'b0, 1'b0);
        en_w = 1'b0; en_p = 1'b0;
        rst_n = 1'b1;
        step();

        beat(40'h0504030201, 8'd3);
        exp_col = 80'h000F_000C_0009_0006_0003;
        chk_out("single", exp_col, 3'd0, 1'b1, 1'b1);
        step();
        chk_out("single_hold", exp_col, 3'd0, 1'b0, 1'b0);

        do_reset();
        for (int b = 0; b < 6; b++) begin
            weight_col = {$urandom(), 8'($urandom())};
            pix = 8'($urandom());
            en_w = 1'b1; en_p = 1'b1;
            exp_col = model(weight_col, pix);
            step();
            chk_out($sformatf("b2b%0d", b), exp_col, 3'(b % 5), 1'b1, b % 5 == 0);
        end
        en_w = 1'b0; en_p = 1'b0;

        beat({5{8'hFF}}, 8'hFF);
`ifdef MULTI_MUL_SIGNED_EN
        exp_col = {5{16'h0001}};
`else
        exp_col = {5{16'hFE01}};
`endif
        chk_out("ext_ff", exp_col, 3'd1, 1'b1, 1'b0);
        beat({5{8'h7F}}, 8'h80);
`ifdef MULTI_MUL_SIGNED_EN
        exp_col = {5{16'hC080}};
`else
        exp_col = {5{16'h3F80}};
`endif
        chk_out("ext_80x7f", exp_col, 3'd2, 1'b1, 1'b0);

        weight_col = 40'h0102030405; pix = 8'd9;
        en_w = 1'b1; en_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("gate_w%0d", i), exp_col, 3'd2, 1'b0, 1'b0);
        end
        en_w = 1'b0; en_p = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("gate_p%0d", i), exp_col, 3'd2, 1'b0, 1'b0);
        end
        beat(40'h0102030405, 8'd9);
        exp_col = 80'h0009_0012_001B_0024_002D;
        chk_out("resume", exp_col, 3'd3, 1'b1, 1'b0);

        do_reset();
        beat(40'h0101010101, 8'd1);
        beat(40'h0202020202, 8'd2);
        beat(40'h0303030303, 8'd3);
        chk_out("pre_rst", {5{16'h0009}}, 3'd2, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 80'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(40'h0A0A0A0A0A, 8'd2);
        chk_out("post_rst", {5{16'h0014}}, 3'd0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
